// File: rtl/ll_engine.sv
// Lunar-lander flight engine: BCD lander state, tick-divided physics update,
// keypad event handling and the FLY/PAUSED/LANDED/CRASHED state machine.
module ll_engine #(
    parameter int                  DIGITS    = 4,
    parameter int                  TICK_DIV  = 4,
    parameter logic [4*DIGITS-1:0] ALTITUDE  = 'h4500,
    parameter logic [4*DIGITS-1:0] VELOCITY  = 'h0,
    parameter logic [4*DIGITS-1:0] FUEL      = 'h800,
    parameter logic [3:0]          THRUST    = 4'h5,
    parameter logic [4*DIGITS-1:0] GRAVITY   = 'h5,
    parameter logic [4*DIGITS-1:0] CRASH_VEL = 'h30
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  keyvalid,
    input  logic [4:0]            keycode,
    output logic [4*DIGITS-1:0]   alt,
    output logic [4*DIGITS-1:0]   vel,
    output logic [4*DIGITS-1:0]   fuel,
    output logic [4*DIGITS-1:0]   thrust,
    output logic [4*DIGITS-1:0]   disp,
    output logic [1:0]            sel,
    output logic                  tick,
    output logic                  flying,
    output logic                  paused,
    output logic                  land,
    output logic                  crash
);

    localparam int W  = 4 * DIGITS;
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {FLY, PAUSED, LANDED, CRASHED} state_t;

    // Digit-wise BCD addition; the final carry is dropped (modulo 10^DIGITS).
    function automatic logic [W-1:0] bcdAdd(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] r;
        logic [4:0]   s;
        logic         c;
        r = '0;
        c = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            s = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0, c};
            c = (s > 5'd9);
            if (c) s = s + 5'd6;
            r[4*i +: 4] = s[3:0];
        end
        return r;
    endfunction

    function automatic logic [W-1:0] bcdSub(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] nines;
        nines = '0;
        for (int i = 0; i < DIGITS; i++) nines[4*i +: 4] = 4'd9 - b[4*i +: 4];
        return bcdAdd(a, bcdAdd(nines, W'(1)));
    endfunction

    function automatic logic isNeg(input logic [W-1:0] a);
        return a[W-1 -: 4] >= 4'd5;
    endfunction

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  alt_q, alt_d, vel_q, vel_d, fuel_q, fuel_d;
    logic [3:0]    thrust_q, thrust_d;
    logic [1:0]    sel_q, sel_d;

    logic [W-1:0]  eff, altT, velT, fuelT, fuelClamp;
    logic          touchdown, safeLanding;

    assign eff         = (fuel_q == '0) ? '0 : W'(thrust_q);
    assign altT        = bcdAdd(alt_q, vel_q);
    assign velT        = bcdAdd(bcdSub(vel_q, GRAVITY), eff);
    assign fuelT       = bcdSub(fuel_q, W'(thrust_q));
    assign fuelClamp   = (fuel_q == '0 || isNeg(fuelT)) ? '0 : fuelT;
    assign touchdown   = isNeg(altT) || (altT == '0);
    assign safeLanding = !isNeg(bcdAdd(vel_q, CRASH_VEL));
    assign tick        = (state_q == FLY) && (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FLY;
            cnt_q    <= '0;
            alt_q    <= ALTITUDE;
            vel_q    <= VELOCITY;
            fuel_q   <= FUEL;
            thrust_q <= THRUST;
            sel_q    <= 2'd3;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            alt_q    <= alt_d;
            vel_q    <= vel_d;
            fuel_q   <= fuel_d;
            thrust_q <= thrust_d;
            sel_q    <= sel_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        alt_d    = alt_q;
        vel_d    = vel_q;
        fuel_d   = fuel_q;
        thrust_d = thrust_q;
        sel_d    = sel_q;

        if (state_q == FLY) cnt_d = tick ? '0 : cnt_q + 1'b1;

        if (tick) begin
            fuel_d = fuelClamp;
            if (touchdown) begin
                alt_d   = '0;
                vel_d   = '0;
                state_d = safeLanding ? LANDED : CRASHED;
            end else begin
                alt_d = altT;
                vel_d = velT;
            end
        end

        // A touchdown on the same edge as a pause key wins; the flight is over.
        if (keyvalid) begin
            if (keycode <= 5'd9 && (state_q == FLY || state_q == PAUSED))
                thrust_d = keycode[3:0];
            if (keycode[4:2] == 3'b100)
                sel_d = keycode[1:0];
            if (keycode == 5'd15) begin
                if (state_q == PAUSED)
                    state_d = FLY;
                else if (state_d == FLY)
                    state_d = PAUSED;
            end
        end
    end

    always_comb begin
        disp = alt_q;
        case (sel_q)
            2'd0:    disp = W'(thrust_q);
            2'd1:    disp = fuel_q;
            2'd2:    disp = vel_q;
            default: disp = alt_q;
        endcase
    end

    assign alt    = alt_q;
    assign vel    = vel_q;
    assign fuel   = fuel_q;
    assign thrust = W'(thrust_q);
    assign sel    = sel_q;
    assign flying = (state_q == FLY);
    assign paused = (state_q == PAUSED);
    assign land   = (state_q == LANDED);
    assign crash  = (state_q == CRASHED);

endmodule

// File: tb/tb_ll_engine.sv
// Bench for ll_engine: directed scenarios plus a randomized keypad run checked
// against an integer (signed, modulo 10000) model of the lander.
module tb_ll_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        keyvalid = 1'b0;
    logic [4:0]  keycode = 5'd0;

    logic [15:0] alt, vel, fuel, thrust, disp;
    logic [1:0]  sel;
    logic        tick, flying, paused, land, crash;

    logic [15:0] lAlt, lVel, lFuel, lThr, lDisp;
    logic [1:0]  lSel;
    logic        lTick, lFly, lPau, lLand, lCrash;

    logic [15:0] fAlt, fVel, fFuel, fThr, fDisp;
    logic [1:0]  fSel;
    logic        fTick, fFly, fPau, fLand, fCrash;

    int nTests = 0;
    int nFail  = 0;

    int mAlt, mVel, mFuel, mThr, mSel, mMode, mCnt;

    ll_engine uDut (
        .clk(clk), .rst(rst), .keyvalid(keyvalid), .keycode(keycode),
        .alt(alt), .vel(vel), .fuel(fuel), .thrust(thrust), .disp(disp),
        .sel(sel), .tick(tick), .flying(flying), .paused(paused),
        .land(land), .crash(crash)
    );

    ll_engine #(.ALTITUDE(16'h10), .VELOCITY(16'h9990)) uLand (
        .clk(clk), .rst(rst), .keyvalid(keyvalid), .keycode(keycode),
        .alt(lAlt), .vel(lVel), .fuel(lFuel), .thrust(lThr), .disp(lDisp),
        .sel(lSel), .tick(lTick), .flying(lFly), .paused(lPau),
        .land(lLand), .crash(lCrash)
    );

    ll_engine #(.FUEL(16'h3)) uFuel (
        .clk(clk), .rst(rst), .keyvalid(keyvalid), .keycode(keycode),
        .alt(fAlt), .vel(fVel), .fuel(fFuel), .thrust(fThr), .disp(fDisp),
        .sel(fSel), .tick(fTick), .flying(fFly), .paused(fPau),
        .land(fLand), .crash(fCrash)
    );

    always #5 clk = ~clk;

    // Model arithmetic: values kept as 0..9999, signed view has 5000..9999 negative.
    function automatic int wrapM(int x);
        return ((x % 10000) + 10000) % 10000;
    endfunction

    function automatic int sv(int x);
        return (x >= 5000) ? x - 10000 : x;
    endfunction

    function automatic logic [15:0] toBcd(int x);
        logic [15:0] r;
        int y;
        y = wrapM(x);
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(y % 10);
            y = y / 10;
        end
        return r;
    endfunction

    function automatic bit modelTick();
        return (mMode == 0) && (mCnt == 3);
    endfunction

    function automatic logic [3:0] modelFlags();
        return 4'(8 >> mMode);
    endfunction

    function automatic logic [15:0] modelDisp();
        case (mSel)
            0:       return toBcd(mThr);
            1:       return toBcd(mFuel);
            2:       return toBcd(mVel);
            default: return toBcd(mAlt);
        endcase
    endfunction

    task automatic modelReset();
        mAlt = 4500; mVel = 0; mFuel = 800; mThr = 5; mSel = 3; mMode = 0; mCnt = 0;
    endtask

    task automatic modelStep(input bit v, input int code);
        int nAlt, nVel, nFuel, nThr, nSel, nMode, nCnt;
        int eff, aT, vT, fT, fC;
        bit tk;
        nAlt = mAlt; nVel = mVel; nFuel = mFuel; nThr = mThr;
        nSel = mSel; nMode = mMode; nCnt = mCnt;
        tk = modelTick();
        if (mMode == 0) nCnt = (mCnt + 1) % 4;
        if (tk) begin
            eff = (mFuel == 0) ? 0 : mThr;
            aT  = wrapM(sv(mAlt) + sv(mVel));
            vT  = wrapM(sv(mVel) - 5 + eff);
            fT  = wrapM(sv(mFuel) - mThr);
            fC  = (mFuel == 0 || sv(fT) < 0) ? 0 : fT;
            nFuel = fC;
            if (sv(aT) <= 0) begin
                nAlt  = 0;
                nVel  = 0;
                nMode = (sv(wrapM(sv(mVel) + 30)) >= 0) ? 2 : 3;
            end else begin
                nAlt = aT;
                nVel = vT;
            end
        end
        if (v) begin
            if (code <= 9 && mMode <= 1) nThr = code;
            if (code >= 16 && code <= 19) nSel = code - 16;
            if (code == 15) begin
                if (mMode == 1) nMode = 0;
                else if (mMode == 0 && nMode == 0) nMode = 1;
            end
        end
        mAlt = nAlt; mVel = nVel; mFuel = nFuel; mThr = nThr;
        mSel = nSel; mMode = nMode; mCnt = nCnt;
    endtask

    // One clock with an optional key; outputs are sampled 1 time unit after the edge.
    task automatic stepCycle(input bit v, input int code);
        keyvalid = v;
        keycode  = 5'(code);
        @(posedge clk);
        modelStep(v, code);
        #1;
        keyvalid = 1'b0;
        keycode  = 5'd0;
    endtask

    task automatic doReset(input bit v, input int code);
        rst      = 1'b1;
        keyvalid = v;
        keycode  = 5'(code);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        keyvalid = 1'b0;
        keycode  = 5'd0;
        modelReset();
    endtask

    task automatic test_reset();
        doReset(0, 0);
        nTests++;
        if ({alt, vel, fuel, thrust} !== {16'h4500, 16'h0000, 16'h0800, 16'h0005}) begin
            nFail++;
            $display("[TB] FAIL reset_qty: got %h/%h/%h/%h expected 4500/0000/0800/0005", alt, vel, fuel, thrust);
        end
        nTests++;
        if ({sel, disp, tick} !== {2'd3, 16'h4500, 1'b0}) begin
            nFail++;
            $display("[TB] FAIL reset_sel: got sel %0d disp %h tick %b expected 3 4500 0", sel, disp, tick);
        end
        nTests++;
        if ({flying, paused, land, crash} !== 4'b1000) begin
            nFail++;
            $display("[TB] FAIL reset_flags: got %b expected 1000", {flying, paused, land, crash});
        end
    endtask

    task automatic test_first_tick();
        doReset(0, 0);
        for (int i = 1; i <= 4; i++) begin
            nTests++;
            if (tick !== (i == 4)) begin
                nFail++;
                $display("[TB] FAIL first_tick_cycle%0d: got %b expected %b", i, tick, (i == 4));
            end
            stepCycle(0, 0);
        end
        nTests++;
        if ({alt, vel, fuel, thrust} !== {16'h4500, 16'h0000, 16'h0795, 16'h0005}) begin
            nFail++;
            $display("[TB] FAIL first_tick_qty: got %h/%h/%h/%h expected 4500/0000/0795/0005", alt, vel, fuel, thrust);
        end
    endtask

    task automatic test_thrust_zero();
        doReset(0, 0);
        stepCycle(1, 0);
        for (int i = 0; i < 3; i++) stepCycle(0, 0);
        nTests++;
        if ({alt, vel, fuel} !== {16'h4500, 16'h9995, 16'h0800}) begin
            nFail++;
            $display("[TB] FAIL thrust0_tick1: got %h/%h/%h expected 4500/9995/0800", alt, vel, fuel);
        end
        for (int i = 0; i < 4; i++) stepCycle(0, 0);
        nTests++;
        if ({alt, vel, fuel} !== {16'h4495, 16'h9990, 16'h0800}) begin
            nFail++;
            $display("[TB] FAIL thrust0_tick2: got %h/%h/%h expected 4495/9990/0800", alt, vel, fuel);
        end
    endtask

    task automatic test_pause();
        int ticksSeen;
        doReset(0, 0);
        stepCycle(0, 0);
        stepCycle(1, 15);
        ticksSeen = 0;
        for (int i = 0; i < 10; i++) begin
            if (tick) ticksSeen++;
            stepCycle(0, 0);
        end
        nTests++;
        if ({ticksSeen[3:0], paused, alt, vel, fuel} !== {4'd0, 1'b1, 16'h4500, 16'h0000, 16'h0800}) begin
            nFail++;
            $display("[TB] FAIL pause_hold: got ticks %0d paused %b %h/%h/%h expected 0 1 4500/0000/0800",
                     ticksSeen, paused, alt, vel, fuel);
        end
        stepCycle(1, 15);
        nTests++;
        if ({flying, tick} !== 2'b10) begin
            nFail++;
            $display("[TB] FAIL pause_resume: got flying %b tick %b expected 1 0", flying, tick);
        end
        stepCycle(0, 0);
        nTests++;
        if (tick !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL pause_frozen_count: got tick %b expected 1", tick);
        end
        stepCycle(0, 0);
        for (int i = 0; i < 3; i++) stepCycle(0, 0);
        nTests++;
        if (tick !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL pause_tick_align: got tick %b expected 1", tick);
        end
        stepCycle(1, 15);
        stepCycle(0, 0);
        stepCycle(0, 0);
        nTests++;
        if ({paused, fuel} !== {1'b1, 16'h0790}) begin
            nFail++;
            $display("[TB] FAIL pause_with_tick: got paused %b fuel %h expected 1 0790", paused, fuel);
        end
    endtask

    task automatic test_select();
        doReset(0, 0);
        stepCycle(1, 17);
        nTests++;
        if ({sel, disp} !== {2'd1, 16'h0800}) begin
            nFail++;
            $display("[TB] FAIL sel_fuel: got %0d %h expected 1 0800", sel, disp);
        end
        stepCycle(1, 12);
        nTests++;
        if ({sel, disp} !== {2'd1, 16'h0800}) begin
            nFail++;
            $display("[TB] FAIL sel_ignored: got %0d %h expected 1 0800", sel, disp);
        end
        stepCycle(1, 18);
        nTests++;
        if ({sel, disp} !== {2'd2, 16'h0000}) begin
            nFail++;
            $display("[TB] FAIL sel_vel: got %0d %h expected 2 0000", sel, disp);
        end
        stepCycle(1, 16);
        nTests++;
        if ({sel, disp} !== {2'd0, 16'h0005}) begin
            nFail++;
            $display("[TB] FAIL sel_thrust: got %0d %h expected 0 0005", sel, disp);
        end
    endtask

    task automatic test_fuel_out();
        doReset(0, 0);
        for (int i = 0; i < 4; i++) stepCycle(0, 0);
        nTests++;
        if ({fAlt, fVel, fFuel} !== {16'h4500, 16'h0000, 16'h0000}) begin
            nFail++;
            $display("[TB] FAIL fuel_tick1: got %h/%h/%h expected 4500/0000/0000", fAlt, fVel, fFuel);
        end
        for (int i = 0; i < 4; i++) stepCycle(0, 0);
        nTests++;
        if ({fAlt, fVel, fFuel} !== {16'h4500, 16'h9995, 16'h0000}) begin
            nFail++;
            $display("[TB] FAIL fuel_tick2: got %h/%h/%h expected 4500/9995/0000", fAlt, fVel, fFuel);
        end
    endtask

    task automatic test_landing();
        int ticksSeen;
        doReset(0, 0);
        for (int i = 0; i < 4; i++) stepCycle(0, 0);
        nTests++;
        if ({lAlt, lVel, lFuel, lFly, lPau, lLand, lCrash} !== {16'h0, 16'h0, 16'h0795, 4'b0010}) begin
            nFail++;
            $display("[TB] FAIL land_touchdown: got %h/%h/%h flags %b expected 0000/0000/0795 0010",
                     lAlt, lVel, lFuel, {lFly, lPau, lLand, lCrash});
        end
        stepCycle(1, 3);
        ticksSeen = 0;
        for (int i = 0; i < 8; i++) begin
            if (lTick) ticksSeen++;
            stepCycle(1, (i == 0) ? 15 : 0);
        end
        nTests++;
        if ({ticksSeen[3:0], lThr, lAlt, lLand} !== {4'd0, 16'h0005, 16'h0000, 1'b1}) begin
            nFail++;
            $display("[TB] FAIL land_terminal: got ticks %0d thr %h alt %h land %b expected 0 0005 0000 1",
                     ticksSeen, lThr, lAlt, lLand);
        end
    endtask

    task automatic test_crash();
        int budget;
        doReset(0, 0);
        stepCycle(1, 0);
        budget = 2000;
        while (!(crash || land) && budget > 0) begin
            stepCycle(0, 0);
            budget--;
        end
        nTests++;
        if ({crash, land, alt, vel} !== {2'b10, 16'h0, 16'h0}) begin
            nFail++;
            $display("[TB] FAIL crash_freefall: got crash %b land %b %h/%h budget %0d expected 1 0 0000/0000",
                     crash, land, alt, vel, budget);
        end
        stepCycle(1, 7);
        stepCycle(1, 15);
        stepCycle(1, 17);
        nTests++;
        if ({thrust, crash, paused, sel, disp} !== {16'h0, 1'b1, 1'b0, 2'd1, 16'h0800}) begin
            nFail++;
            $display("[TB] FAIL crash_keys: got thr %h crash %b paused %b sel %0d disp %h expected 0000 1 0 1 0800",
                     thrust, crash, paused, sel, disp);
        end
    endtask

    task automatic test_reset_priority();
        doReset(0, 0);
        nTests++;
        if ({flying, crash, alt} !== {1'b1, 1'b0, 16'h4500}) begin
            nFail++;
            $display("[TB] FAIL reset_from_crash: got fly %b crash %b alt %h expected 1 0 4500", flying, crash, alt);
        end
        stepCycle(1, 9);
        stepCycle(1, 18);
        for (int i = 0; i < 5; i++) stepCycle(0, 0);
        doReset(1, 15);
        nTests++;
        if ({alt, vel, fuel, thrust, sel, flying, paused} !== {16'h4500, 16'h0, 16'h0800, 16'h5, 2'd3, 2'b10}) begin
            nFail++;
            $display("[TB] FAIL reset_midflight: got %h/%h/%h/%h sel %0d fly %b paused %b",
                     alt, vel, fuel, thrust, sel, flying, paused);
        end
    endtask

    task automatic test_random();
        int pick, code, after;
        bit v;
        for (int ep = 0; ep < 4; ep++) begin
            doReset(0, 0);
            after = 0;
            for (int cyc = 0; cyc < 800 && after < 10; cyc++) begin
                v = ($urandom_range(0, 99) < 15);
                pick = $urandom_range(0, 9);
                code = (pick < 6) ? $urandom_range(0, 9) :
                       (pick < 7) ? 15 :
                       (pick < 9) ? $urandom_range(16, 19) : $urandom_range(0, 31);
                nTests++;
                if (tick !== modelTick()) begin
                    nFail++;
                    $display("[TB] FAIL rand_tick ep%0d cyc%0d: got %b expected %b", ep, cyc, tick, modelTick());
                end
                stepCycle(v, code);
                nTests++;
                if ({alt, vel, fuel, thrust} !== {toBcd(mAlt), toBcd(mVel), toBcd(mFuel), toBcd(mThr)}) begin
                    nFail++;
                    $display("[TB] FAIL rand_qty ep%0d cyc%0d: got %h/%h/%h/%h expected %h/%h/%h/%h", ep, cyc,
                             alt, vel, fuel, thrust, toBcd(mAlt), toBcd(mVel), toBcd(mFuel), toBcd(mThr));
                end
                nTests++;
                if ({flying, paused, land, crash, sel, disp} !== {modelFlags(), 2'(mSel), modelDisp()}) begin
                    nFail++;
                    $display("[TB] FAIL rand_state ep%0d cyc%0d: got %b sel %0d disp %h expected %b sel %0d disp %h",
                             ep, cyc, {flying, paused, land, crash}, sel, disp, modelFlags(), mSel, modelDisp());
                end
                if (mMode >= 2) after++;
            end
        end
    endtask

    initial begin
        modelReset();
        test_reset();
        test_first_tick();
        test_thrust_zero();
        test_pause();
        test_select();
        test_fuel_out();
        test_landing();
        test_crash();
        test_reset_priority();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
